// File: rtl/instruction_streamer_if.sv
// Bus between the host/load path, the instruction streamer and the cpu core.
// The master side loads and controls the streamer and consumes the stream.
// The slave side is the streamer itself.
interface instruction_streamer_if #(
    parameter int INSTRUCTION_WIDTH  = 32,
    parameter int MAX_PROGRAM_LENGTH = 64,
    parameter int ADDR_WIDTH         = $clog2(MAX_PROGRAM_LENGTH),
    parameter int LOOP_COUNT_WIDTH   = 8
) ();
    // host load / control
    logic                         load_enable_in;
    logic [ADDR_WIDTH-1:0]        load_address_in;
    logic [INSTRUCTION_WIDTH-1:0] load_data_in;
    logic [ADDR_WIDTH:0]          program_length_in;
    logic                         loop_mode_in;
    logic [LOOP_COUNT_WIDTH-1:0]  loop_count_in;
    logic                         start_in;
    logic                         stop_in;
    logic                         stall_in;
    // stream towards the cpu and status
    logic [INSTRUCTION_WIDTH-1:0] current_instruction_out;
    logic                         instruction_valid_out;
    logic [ADDR_WIDTH-1:0]        program_counter_out;
    logic                         busy_out;
    logic                         done_out;
    logic                         error_out;

    modport master (
        output load_enable_in, load_address_in, load_data_in,
        output program_length_in, loop_mode_in, loop_count_in,
        output start_in, stop_in, stall_in,
        input  current_instruction_out, instruction_valid_out, program_counter_out,
        input  busy_out, done_out, error_out
    );

    modport slave (
        input  load_enable_in, load_address_in, load_data_in,
        input  program_length_in, loop_mode_in, loop_count_in,
        input  start_in, stop_in, stall_in,
        output current_instruction_out, instruction_valid_out, program_counter_out,
        output busy_out, done_out, error_out
    );
endinterface

// File: rtl/instruction_streamer.sv
// Instruction streamer: loadable program RAM that feeds the cpu one word per
// cycle, with stall back-pressure, stop/abort, program length and loop mode.
// The RAM is read combinationally so the registered output presents the word
// addressed by the next pc one cycle after start, with no gap between passes.
module instruction_streamer #(
    parameter int INSTRUCTION_WIDTH  = 32,
    parameter int MAX_PROGRAM_LENGTH = 64,
    parameter int ADDR_WIDTH         = $clog2(MAX_PROGRAM_LENGTH),
    parameter int LOOP_COUNT_WIDTH   = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    instruction_streamer_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_PROGRAM_LENGTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
    logic [ADDR_WIDTH:0]          len_q, len_d;
    logic                         loop_mode_q, loop_mode_d;
    logic                         loop_inf_q, loop_inf_d;
    logic [LOOP_COUNT_WIDTH-1:0]  loop_cnt_q, loop_cnt_d;

    // output stage: _p0 is the value computed this cycle, _p1 the registered output
    logic [INSTRUCTION_WIDTH-1:0] instr_p0, instr_p1;
    logic                         vld_p0, vld_p1;
    logic                         done_p0, done_p1;
    logic                         error_p0, error_p1;

    logic [INSTRUCTION_WIDTH-1:0] mem [MAX_PROGRAM_LENGTH];
    logic                         addr_ok;
    logic                         wr_en;
    logic                         at_last;
    logic                         len_ok;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [INSTRUCTION_WIDTH-1:0] rd_data;

    // Decode of write permission, pass end and start-length legality.
    always_comb begin
        addr_ok = ({1'b0, bus.load_address_in} < MAX_LEN);
        wr_en   = bus.load_enable_in && (state_q == IDLE) && addr_ok;
        at_last = ({1'b0, pc_q} == (len_q - 1'b1));
        len_ok  = (bus.program_length_in != '0) && (bus.program_length_in <= MAX_LEN);
    end

    // Address of the word to present at the next edge; a same-cycle write to
    // that address is forwarded so a load+start streams the freshly written word.
    always_comb begin
        rd_addr = '0;
        if (state_q == RUN && !at_last) begin
            rd_addr = pc_q + 1'b1;
        end
        rd_data = mem[rd_addr];
        if (wr_en && (bus.load_address_in == rd_addr)) begin
            rd_data = bus.load_data_in;
        end
    end

    // Program RAM write port; contents survive reset.
    always_ff @(posedge clock_in) begin
        if (wr_en) begin
            mem[bus.load_address_in] <= bus.load_data_in;
        end
    end

    // Next-state and next-output logic of the streaming FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        loop_mode_d = loop_mode_q;
        loop_inf_d  = loop_inf_q;
        loop_cnt_d  = loop_cnt_q;
        instr_p0    = instr_p1;
        vld_p0      = vld_p1;
        done_p0     = 1'b0;
        error_p0    = bus.load_enable_in && !wr_en;

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    if (len_ok) begin
                        state_d     = RUN;
                        pc_d        = '0;
                        len_d       = bus.program_length_in;
                        loop_mode_d = bus.loop_mode_in;
                        loop_inf_d  = bus.loop_mode_in && (bus.loop_count_in == '0);
                        loop_cnt_d  = bus.loop_count_in;
                        instr_p0    = rd_data;
                        vld_p0      = 1'b1;
                    end else begin
                        error_p0 = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.stop_in) begin
                    state_d  = IDLE;
                    pc_d     = '0;
                    instr_p0 = '0;
                    vld_p0   = 1'b0;
                end else if (!bus.stall_in) begin
                    if (at_last) begin
                        if (loop_mode_q && (loop_inf_q || loop_cnt_q != '0)) begin
                            pc_d     = '0;
                            instr_p0 = rd_data;
                            if (!loop_inf_q) begin
                                loop_cnt_d = loop_cnt_q - 1'b1;
                            end
                        end else begin
                            state_d  = DONE;
                            pc_d     = '0;
                            instr_p0 = '0;
                            vld_p0   = 1'b0;
                        end
                    end else begin
                        pc_d     = pc_q + 1'b1;
                        instr_p0 = rd_data;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_p0 = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                instr_p0 = '0;
                vld_p0   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; everything clears at once on reset.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            loop_mode_q <= 1'b0;
            loop_inf_q  <= 1'b0;
            loop_cnt_q  <= '0;
            instr_p1    <= '0;
            vld_p1      <= 1'b0;
            done_p1     <= 1'b0;
            error_p1    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            loop_mode_q <= loop_mode_d;
            loop_inf_q  <= loop_inf_d;
            loop_cnt_q  <= loop_cnt_d;
            instr_p1    <= instr_p0;
            vld_p1      <= vld_p0;
            done_p1     <= done_p0;
            error_p1    <= error_p0;
        end
    end

    assign bus.current_instruction_out = instr_p1;
    assign bus.instruction_valid_out   = vld_p1;
    assign bus.program_counter_out     = pc_q;
    assign bus.busy_out                = (state_q == RUN);
    assign bus.done_out                = done_p1;
    assign bus.error_out               = error_p1;

endmodule

// File: tb/tb_instruction_streamer.sv
// Directed bench for instruction_streamer with a scoreboard of expected
// (instruction, pc) pairs consumed by a monitor on every valid cycle.
module tb_instruction_streamer;
    localparam int IW   = 32;
    localparam int MAXL = 64;
    localparam int AW   = 6;
    localparam int LCW  = 8;

    typedef struct packed {
        logic [IW-1:0] ins;
        logic [AW-1:0] pc;
    } exp_t;

    logic     clk   = 1'b0;
    logic     rst_n = 1'b0;
    int       vectors     = 0;
    int       miscompares = 0;
    int       vld_total   = 0;
    int       done_total  = 0;
    exp_t     sb[$];
    exp_t     mon_e;
    logic [IW-1:0] model [MAXL];

    instruction_streamer_if #(.INSTRUCTION_WIDTH(IW), .MAX_PROGRAM_LENGTH(MAXL),
                              .ADDR_WIDTH(AW), .LOOP_COUNT_WIDTH(LCW)) bus ();

    instruction_streamer #(.INSTRUCTION_WIDTH(IW), .MAX_PROGRAM_LENGTH(MAXL),
                           .ADDR_WIDTH(AW), .LOOP_COUNT_WIDTH(LCW)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: every valid word must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done_out) done_total++;
            if (bus.instruction_valid_out) begin
                vld_total++;
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(sb.size()), 64'd1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("stream_ins", bus.current_instruction_out, mon_e.ins);
                    chk("stream_pc", bus.program_counter_out, mon_e.pc);
                end
            end else begin
                chk("idle_zero", bus.current_instruction_out, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [IW-1:0] d, input bit update);
        bus.load_enable_in  = 1'b1;
        bus.load_address_in = AW'(a);
        bus.load_data_in    = d;
        tick();
        bus.load_enable_in  = 1'b0;
        if (update) model[a] = d;
    endtask

    task automatic push_word(input int i);
        exp_t e;
        e.ins = model[i];
        e.pc  = AW'(i);
        sb.push_back(e);
    endtask

    task automatic push_prog(input int len, input int passes);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < len; i++) push_word(i);
    endtask

    task automatic start_prog(input int len, input bit lm, input int lc);
        bus.program_length_in = (AW+1)'(len);
        bus.loop_mode_in      = lm;
        bus.loop_count_in     = LCW'(lc);
        bus.start_in          = 1'b1;
        tick();
        bus.start_in          = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!bus.done_out && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("done_timeout", 64'(n), 64'(bound - 1));
    endtask

    int n, v0, d0;

    initial begin
        bus.load_enable_in = 0; bus.load_address_in = '0; bus.load_data_in = '0;
        bus.program_length_in = '0; bus.loop_mode_in = 0; bus.loop_count_in = '0;
        bus.start_in = 0; bus.stop_in = 0; bus.stall_in = 0;

        // reset state
        #3;
        chk("rst_ins",   bus.current_instruction_out, 0);
        chk("rst_valid", bus.instruction_valid_out, 0);
        chk("rst_pc",    bus.program_counter_out, 0);
        chk("rst_busy",  bus.busy_out, 0);
        chk("rst_done",  bus.done_out, 0);
        chk("rst_error", bus.error_out, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic 4-word program A,B,C,D
        load_word(0, 32'hA000_000A, 1);
        load_word(1, 32'hB000_000B, 1);
        load_word(2, 32'hC000_000C, 1);
        load_word(3, 32'hD000_000D, 1);
        chk("load_no_error", bus.error_out, 0);
        v0 = vld_total; d0 = done_total;
        push_prog(4, 1);
        start_prog(4, 0, 0);
        chk("lat1_valid", bus.instruction_valid_out, 1);
        chk("lat1_ins",   bus.current_instruction_out, 32'hA000_000A);
        chk("lat1_pc",    bus.program_counter_out, 0);
        chk("lat1_busy",  bus.busy_out, 1);
        wait_done(50, n);
        chk("t1_done_latency", 64'(n), 5);
        tick(); tick();
        chk("t1_valid_cnt", 64'(vld_total - v0), 4);
        chk("t1_done_cnt",  64'(done_total - d0), 1);
        chk("t1_sb_empty",  64'(sb.size()), 0);
        chk("t1_busy",      bus.busy_out, 0);

        // stall while B is shown
        v0 = vld_total; d0 = done_total;
        push_word(0); push_word(1); push_word(1); push_word(1); push_word(2); push_word(3);
        start_prog(4, 0, 0);
        tick();
        bus.stall_in = 1'b1;
        tick();
        chk("stall_pc",  bus.program_counter_out, 1);
        chk("stall_ins", bus.current_instruction_out, 32'hB000_000B);
        tick();
        bus.stall_in = 1'b0;
        tick();
        chk("after_stall_ins", bus.current_instruction_out, 32'hC000_000C);
        wait_done(50, n);
        chk("t2_done_latency", 64'(n), 3);
        tick(); tick();
        chk("t2_valid_cnt", 64'(vld_total - v0), 6);
        chk("t2_done_cnt",  64'(done_total - d0), 1);

        // loop mode, two extra passes of X,Y,Z
        load_word(0, 32'h1111_0001, 1);
        load_word(1, 32'h2222_0002, 1);
        load_word(2, 32'h3333_0003, 1);
        v0 = vld_total; d0 = done_total;
        push_prog(3, 3);
        start_prog(3, 1, 2);
        wait_done(100, n);
        chk("t3_done_latency", 64'(n), 10);
        tick(); tick();
        chk("t3_valid_cnt", 64'(vld_total - v0), 9);
        chk("t3_done_cnt",  64'(done_total - d0), 1);

        // infinite loop for 20 passes, then stop (with stall also high)
        v0 = vld_total; d0 = done_total;
        push_prog(3, 20);
        start_prog(3, 1, 0);
        n = 0;
        while (sb.size() != 1 && n < 200) begin
            tick();
            n++;
        end
        chk("inf_reached", 64'(sb.size()), 1);
        bus.stop_in = 1'b1; bus.stall_in = 1'b1;
        tick();
        bus.stop_in = 1'b0; bus.stall_in = 1'b0;
        chk("stop_valid", bus.instruction_valid_out, 0);
        chk("stop_ins",   bus.current_instruction_out, 0);
        chk("stop_busy",  bus.busy_out, 0);
        tick(); tick(); tick();
        chk("t4_valid_cnt", 64'(vld_total - v0), 60);
        chk("t4_no_done",   64'(done_total - d0), 0);
        chk("t4_sb_empty",  64'(sb.size()), 0);

        // illegal lengths
        start_prog(0, 0, 0);
        chk("len0_error", bus.error_out, 1);
        chk("len0_busy",  bus.busy_out, 0);
        tick();
        chk("len0_error_clear", bus.error_out, 0);
        start_prog(65, 0, 0);
        chk("len65_error", bus.error_out, 1);
        chk("len65_busy",  bus.busy_out, 0);
        tick();
        chk("len65_error_clear", bus.error_out, 0);

        // load attempt while running is rejected
        model[3] = 32'hD000_000D;
        v0 = vld_total;
        push_prog(4, 1);
        start_prog(4, 0, 0);
        load_word(1, 32'hBAD0_BAD0, 0);
        chk("run_load_error", bus.error_out, 1);
        wait_done(50, n);
        tick(); tick();
        chk("t6_valid_cnt", 64'(vld_total - v0), 4);
        push_prog(2, 1);
        start_prog(2, 0, 0);
        wait_done(50, n);
        chk("readback_latency", 64'(n), 3);
        tick();

        // load and start in the same cycle, length 1
        v0 = vld_total; d0 = done_total;
        bus.load_enable_in = 1'b1; bus.load_address_in = '0; bus.load_data_in = 32'h5A5A_0F0F;
        model[0] = 32'h5A5A_0F0F;
        push_prog(1, 1);
        start_prog(1, 0, 0);
        bus.load_enable_in = 1'b0;
        chk("ldst_ins", bus.current_instruction_out, 32'h5A5A_0F0F);
        wait_done(50, n);
        chk("len1_done_latency", 64'(n), 2);
        tick(); tick();
        chk("len1_valid_cnt", 64'(vld_total - v0), 1);
        chk("len1_done_cnt",  64'(done_total - d0), 1);

        // asynchronous reset in the middle of a stream
        push_prog(4, 1);
        start_prog(4, 0, 0);
        tick(); tick();
        chk("pre_rst_pc", bus.program_counter_out, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ins",   bus.current_instruction_out, 0);
        chk("arst_valid", bus.instruction_valid_out, 0);
        chk("arst_pc",    bus.program_counter_out, 0);
        chk("arst_busy",  bus.busy_out, 0);
        sb.delete();
        #2 rst_n = 1'b1;
        tick();
        v0 = vld_total; d0 = done_total;
        push_prog(4, 1);
        start_prog(4, 0, 0);
        chk("replay_ins0", bus.current_instruction_out, 32'h5A5A_0F0F);
        wait_done(50, n);
        chk("replay_done_latency", 64'(n), 5);
        tick(); tick();
        chk("replay_valid_cnt", 64'(vld_total - v0), 4);
        chk("replay_done_cnt",  64'(done_total - d0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
